// File: rtl/odd_even_sort.sv
// Iterative odd-even transposition sorter: one compare-and-swap phase per clock over a
// single working array, with early exit after two consecutive swap-free phases.
module odd_even_sort #(
    parameter int p_DATA_WIDTH = 32,
    parameter int p_COUNT      = 8
) (
    input  logic                              i_CLK,
    input  logic                              i_RST_N,
    input  logic                              i_VALID,
    output logic                              o_READY,
    input  logic [p_COUNT*p_DATA_WIDTH-1:0]   i_DATA,
    input  logic                              i_DESCEND,
    output logic                              o_VALID,
    input  logic                              i_READY,
    output logic [p_COUNT*p_DATA_WIDTH-1:0]   o_DATA,
    output logic [$clog2(p_COUNT*(p_COUNT-1)/2+1)-1:0] o_SWAPS,
    output logic                              o_BUSY
);
    localparam int c_SW = $clog2(p_COUNT*(p_COUNT-1)/2+1);
    localparam int c_PW = $clog2(p_COUNT);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SORT = 2'd1, ST_DONE = 2'd2} state_t;

    state_t                  state_q;
    logic [p_DATA_WIDTH-1:0] arr_q [p_COUNT];
    logic [p_DATA_WIDTH-1:0] arr_d [p_COUNT];
    logic [c_SW-1:0]         swaps_q;
    logic [c_PW-1:0]         phase_q;
    logic                    desc_q;
    logic                    zero_prev_q;
    logic                    ready_q;
    logic                    valid_q;
    logic                    busy_q;
    logic [c_SW-1:0]         phase_swaps_s;
    logic                    last_phase_s;

    // One phase of the network: disjoint pairs selected by phase parity, strict compare only
    always_comb begin
        arr_d         = arr_q;
        phase_swaps_s = '0;
        for (int j = 0; j < p_COUNT-1; j++) begin
            if ((j % 2) == int'(phase_q[0])) begin
                if (desc_q ? (arr_q[j] < arr_q[j+1]) : (arr_q[j] > arr_q[j+1])) begin
                    arr_d[j]      = arr_q[j+1];
                    arr_d[j+1]    = arr_q[j];
                    phase_swaps_s = phase_swaps_s + c_SW'(1);
                end else begin
                    phase_swaps_s = phase_swaps_s;
                end
            end else begin
                phase_swaps_s = phase_swaps_s;
            end
        end
    end

    // Two quiet phases in a row cover both parities, so the array is provably ordered
    always_comb begin
        last_phase_s = (phase_q == c_PW'(p_COUNT-1)) ||
                       ((phase_q != '0) && zero_prev_q && (phase_swaps_s == '0));
    end

    // Control FSM, working array and registered handshake outputs
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q     <= ST_IDLE;
            for (int k = 0; k < p_COUNT; k++) begin
                arr_q[k] <= '0;
            end
            swaps_q     <= '0;
            phase_q     <= '0;
            desc_q      <= 1'b0;
            zero_prev_q <= 1'b0;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_VALID) begin
                        for (int k = 0; k < p_COUNT; k++) begin
                            arr_q[k] <= i_DATA[k*p_DATA_WIDTH +: p_DATA_WIDTH];
                        end
                        desc_q      <= i_DESCEND;
                        swaps_q     <= '0;
                        phase_q     <= '0;
                        zero_prev_q <= 1'b0;
                        ready_q     <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_SORT;
                    end
                end
                ST_SORT: begin
                    arr_q       <= arr_d;
                    swaps_q     <= swaps_q + phase_swaps_s;
                    zero_prev_q <= (phase_swaps_s == '0);
                    phase_q     <= phase_q + c_PW'(1);
                    if (last_phase_s) begin
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (i_READY) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < p_COUNT; g++) begin : g_pack
        assign o_DATA[g*p_DATA_WIDTH +: p_DATA_WIDTH] = arr_q[g];
    end

    assign o_SWAPS = swaps_q;
    assign o_READY = ready_q;
    assign o_VALID = valid_q;
    assign o_BUSY  = busy_q;

endmodule

// File: tb/tb_odd_even_sort.sv
// Scoreboard bench for odd_even_sort: stimulus pushes hand-computed results, a negedge
// monitor pops and compares on each output handshake and checks output latency.
module tb_odd_even_sort;
    localparam int W  = 32;
    localparam int N  = 8;
    localparam int SW = $clog2(N*(N-1)/2+1);
    localparam int DW = W*N;

    logic          i_CLK = 1'b0;
    logic          i_RST_N = 1'b0;
    logic          i_VALID = 1'b0;
    logic          i_DESCEND = 1'b0;
    logic          i_READY = 1'b0;
    logic [DW-1:0] i_DATA = '0;
    logic          o_READY, o_VALID, o_BUSY;
    logic [DW-1:0] o_DATA;
    logic [SW-1:0] o_SWAPS;

    odd_even_sort #(.p_DATA_WIDTH(W), .p_COUNT(N)) dut (
        .i_CLK(i_CLK), .i_RST_N(i_RST_N), .i_VALID(i_VALID), .o_READY(o_READY),
        .i_DATA(i_DATA), .i_DESCEND(i_DESCEND), .o_VALID(o_VALID), .i_READY(i_READY),
        .o_DATA(o_DATA), .o_SWAPS(o_SWAPS), .o_BUSY(o_BUSY)
    );

    always #5 i_CLK = ~i_CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge i_CLK) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        int            lat;
        int            acc;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm);
        total++;
        bad++;
        $display("FAIL %s", nm);
    endtask

    function automatic logic [DW-1:0] pk(input logic [W-1:0] e0, e1, e2, e3, e4, e5, e6, e7);
        return {e7, e6, e5, e4, e3, e2, e1, e0};
    endfunction

    // Monitor: latency on the rising edge of o_VALID, data/swaps on each handshake
    logic prev_v = 1'b0;
    exp_t mon_e;
    always @(negedge i_CLK) begin
        if (o_VALID && !prev_v) begin
            if (exp_q.size() == 0) flag("spurious_valid");
            else if (exp_q[0].lat >= 0)
                chk("latency", DW'(cyc - exp_q[0].acc), DW'(exp_q[0].lat));
        end
        if (o_VALID && i_READY) begin
            if (exp_q.size() == 0) flag("unexpected_output");
            else begin
                mon_e = exp_q.pop_front();
                chk("data", o_DATA, mon_e.d);
                chk("swaps", DW'(o_SWAPS), DW'(mon_e.s));
            end
        end
        prev_v = o_VALID;
    end

    // Called at posedge+1; returns at posedge+1 just after the accept edge
    task automatic send(input logic [DW-1:0] d, input logic desc, input logic [DW-1:0] ed,
                        input logic [SW-1:0] es, input int lat);
        exp_t e;
        int   n = 0;
        while (!o_READY && n < 200) begin
            @(posedge i_CLK); #1; n++;
        end
        if (!o_READY) flag("ready_timeout");
        i_DATA = d; i_DESCEND = desc; i_VALID = 1'b1;
        @(posedge i_CLK); #1;
        i_VALID = 1'b0; i_DESCEND = ~desc; i_DATA = ~d;
        e.d = ed; e.s = es; e.lat = lat; e.acc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!o_VALID && n < 200) begin
            @(posedge i_CLK); #1; n++;
        end
        if (!o_VALID) flag("valid_timeout");
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!o_READY && n < 200) begin
            @(posedge i_CLK); #1; n++;
        end
        if (!o_READY) flag("idle_timeout");
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, DW'(o_VALID), DW'(0));
        chk({tag, "_busy"},  DW'(o_BUSY),  DW'(0));
        chk({tag, "_ready"}, DW'(o_READY), DW'(1));
        chk({tag, "_data"},  o_DATA,       '0);
        chk({tag, "_swaps"}, DW'(o_SWAPS), DW'(0));
    endtask

    logic [DW-1:0] rev8, asc8;
    initial begin
        rev8 = pk(32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1);
        asc8 = pk(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8);

        #12;
        chk_reset_outputs("por");
        @(posedge i_CLK); #1;
        i_RST_N = 1'b1;
        i_READY = 1'b1;

        // Fully reversed: every phase does work, 28 swaps, done after edge t+8
        send(rev8, 1'b0, asc8, 5'd28, 8);
        chk("sort_busy",  DW'(o_BUSY),  DW'(1));
        chk("sort_ready", DW'(o_READY), DW'(0));
        wait_idle();

        // Already ordered: two quiet phases, done after edge t+2
        send(asc8, 1'b0, asc8, 5'd0, 2);
        wait_idle();

        // Descending with duplicates: strict-compare swap count is 8
        send(pk(32'd3, 32'd9, 32'd3, 32'd0, 32'd9, 32'd1, 32'd0, 32'd3), 1'b1,
             pk(32'd9, 32'd9, 32'd3, 32'd3, 32'd3, 32'd1, 32'd0, 32'd0), 5'd8, -1);
        wait_idle();

        // Unsigned extremes, ascending: 13 strict inversions
        send(pk(32'hFFFFFFFF, 32'h0, 32'h80000000, 32'h1, 32'h7FFFFFFF, 32'h0, 32'h2, 32'hFFFFFFFF),
             1'b0,
             pk(32'h0, 32'h0, 32'h1, 32'h2, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF),
             5'd13, -1);
        wait_idle();

        // Backpressure in DONE with ignored i_VALID pulses
        i_READY = 1'b0;
        send(asc8, 1'b1, rev8, 5'd28, 8);
        wait_valid();
        for (int c = 0; c < 5; c++) begin
            i_VALID = c[0];
            i_DATA  = pk(32'hDEAD0000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1);
            chk("bp_valid", DW'(o_VALID), DW'(1));
            chk("bp_ready", DW'(o_READY), DW'(0));
            chk("bp_data",  o_DATA, rev8);
            chk("bp_swaps", DW'(o_SWAPS), DW'(28));
            @(posedge i_CLK); #1;
        end
        i_VALID = 1'b0;
        i_READY = 1'b1;
        @(posedge i_CLK); #1;
        chk("bp_release_ready", DW'(o_READY), DW'(1));
        chk("bp_release_valid", DW'(o_VALID), DW'(0));

        // Reset in the middle of a reversed sort discards the block
        send(rev8, 1'b0, asc8, 5'd28, 8);
        repeat (3) @(posedge i_CLK);
        #3;
        i_RST_N = 1'b0;
        void'(exp_q.pop_back());
        #1;
        chk_reset_outputs("midrst");
        @(posedge i_CLK); #1;
        i_RST_N = 1'b1;
        send(rev8, 1'b0, asc8, 5'd28, 8);
        wait_idle();

        for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge i_CLK);
        if (exp_q.size() != 0) flag("scoreboard_not_drained");
        @(posedge i_CLK); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
